// File: rtl/gng_ctrl_pkg.sv
// rtl/gng_ctrl_pkg.sv - shared state encoding, default parameters and clip helper for the GNG sample controller
package gng_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          SAMPLE_W       = 32;
    localparam int          PIPE_LAT_DEF   = 12;
    localparam int          FIFO_DEPTH_DEF = 16;
    localparam int          CNT_W_DEF      = 16;
    localparam logic [31:0] CLIP_MAX_DEF   = 32'h0300_0000;

    // Sign-magnitude saturation: magnitude limited to bound, sign bit untouched.
    function automatic logic [SAMPLE_W-1:0] clip_sample(input logic [SAMPLE_W-1:0] s,
                                                        input logic [SAMPLE_W-2:0] bound);
        return {s[SAMPLE_W-1], (s[SAMPLE_W-2:0] > bound) ? bound : s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/gng_sample_ctrl_if.sv
// rtl/gng_sample_ctrl_if.sv - valid/ready sample stream from the GNG sample controller
interface gng_sample_ctrl_if;
    import gng_ctrl_pkg::*;

    logic                m_valid;
    logic                m_ready;
    logic [SAMPLE_W-1:0] m_data;

    modport master (output m_valid, output m_data, input  m_ready);
    modport slave  (input  m_valid, input  m_data, output m_ready);

endinterface

// File: rtl/gng_sync_fifo.sv
// rtl/gng_sync_fifo.sv - register-array FIFO whose head is presented straight from flops
module gng_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/gng_sample_ctrl.sv
// rtl/gng_sample_ctrl.sv - credit-controlled sequencer and output buffer for the GNG core
// Optional: define GNG_CLIP_EN to saturate sample magnitude to CLIP_MAX before buffering.
module gng_sample_ctrl
    import gng_ctrl_pkg::*;
#(
    parameter int          PIPE_LAT   = PIPE_LAT_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int          CNT_W      = CNT_W_DEF,
    parameter logic [31:0] CLIP_MAX   = CLIP_MAX_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                gng_ce,
    input  logic                gng_valid,
    input  logic [SAMPLE_W-1:0] gng_data,
    output logic                ovf_err,
    gng_sample_ctrl_if.master   m
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = FW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gng_sample_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
        $error("gng_sample_ctrl: PIPE_LAT must be >= 1");
    end
    if (CLIP_MAX[31]) begin : g_bad_clip
        $error("gng_sample_ctrl: CLIP_MAX must be a magnitude (bit 31 clear)");
    end

    state_t              state, state_nx;
    logic [CNT_W:0]      target, target_nx;
    logic [CNT_W:0]      issued, issued_nx;
    logic [CNT_W:0]      delivered, delivered_nx;
    logic [OW-1:0]       inflight, inflight_nx;
    logic [OW-1:0]       fifo_cnt_nx;
    logic [FW-1:0]       fifo_cnt;
    logic                fifo_full, fifo_empty;
    logic                start_ok, accept_valid, pop, push_ok, ce_nx;
    logic [SAMPLE_W-1:0] wdata;

    assign start_ok     = (state == ST_IDLE) & start;
    assign accept_valid = gng_valid & ((state == ST_RUN) | (state == ST_DRAIN));
    assign pop          = m.m_valid & m.m_ready;
    assign push_ok      = accept_valid & (~fifo_full | pop);
    assign busy         = (state != ST_IDLE);
    assign m.m_valid    = ~fifo_empty;

`ifdef GNG_CLIP_EN
    assign wdata = clip_sample(gng_data, CLIP_MAX[30:0]);
`else
    assign wdata = gng_data;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = (count == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (issued == target) state_nx = ST_DRAIN;
            ST_DRAIN: if (delivered == target) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // gng_ce is registered, so credit is judged on the occupancy it will see next cycle.
    always_comb begin
        target_nx    = start_ok ? {1'b0, count} : target;
        issued_nx    = start_ok ? '0 : issued + (CNT_W+1)'(gng_ce);
        delivered_nx = start_ok ? '0 : delivered + (CNT_W+1)'(pop);
        inflight_nx  = start_ok ? '0 : inflight + OW'(gng_ce) - OW'(accept_valid);
        fifo_cnt_nx  = OW'(fifo_cnt) + OW'(push_ok) - OW'(pop);
        ce_nx        = (state_nx == ST_RUN) && (issued_nx < target_nx) &&
                       ((inflight_nx + fifo_cnt_nx) < OW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            target    <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= '0;
            gng_ce    <= 1'b0;
            done      <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            target    <= target_nx;
            issued    <= issued_nx;
            delivered <= delivered_nx;
            inflight  <= inflight_nx;
            gng_ce    <= ce_nx;
            done      <= (state == ST_DONE);
            ovf_err   <= ovf_err | (accept_valid & fifo_full & ~pop);
        end
    end

    gng_sync_fifo #(
        .DATA_W (SAMPLE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (m.m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule
